// File: rtl/msglog_pkg.sv
// Shared constants, FSM state type and modulo-index helper for the message log.
package msglog_pkg;

  localparam int unsigned CHAR_W = 8;

  localparam logic [16*CHAR_W-1:0] BLANK_LINE = "[     blank    ]";

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_REFRESH = 1'b1
  } state_t;

  // (a - b) mod hist for a < hist and b <= 2*hist; explicit wrap so any hist works
  function automatic int unsigned wrap_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned hist);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d += int'(hist);
    if (d < 0) d += int'(hist);
    return unsigned'(d);
  endfunction

endpackage

// File: rtl/msglog_ram.sv
// Simple dual-port line store: one write port, one registered read port (BRAM style).
module msglog_ram #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned WIDTH   = 128
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(ENTRIES)-1:0] waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(ENTRIES)-1:0] raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/message_log.sv
// Scrolling history of CHARS-wide text lines with a DEPTH-line flat view that is
// rebuilt one slot per cycle from a circular RAM after every push/clear/scroll.
module message_log
  import msglog_pkg::*;
#(
  parameter int unsigned               CHARS = 16,
  parameter int unsigned               DEPTH = 5,
  parameter int unsigned               HIST  = 8,
  parameter logic [CHARS*CHAR_W-1:0]   BLANK = BLANK_LINE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_valid,
  input  logic [CHARS*CHAR_W-1:0]         push_line,
  output logic                            push_ready,
  input  logic                            clear,
  input  logic                            scroll_up,
  input  logic                            scroll_down,
  output logic [DEPTH*CHARS*CHAR_W-1:0]   view,
  output logic [$clog2(HIST+1)-1:0]       count,
  output logic [$clog2(HIST)-1:0]         scroll_pos,
  output logic                            overflow,
  output logic                            busy
);

  localparam int unsigned LINE_W = CHARS * CHAR_W;
  localparam int unsigned PTR_W  = $clog2(HIST);
  localparam int unsigned CNT_W  = $clog2(HIST + 1);
  localparam int unsigned K_W    = $clog2(DEPTH + 1);

  state_t                        state;
  logic                          started;
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_addr;
  logic [LINE_W-1:0]             rd_data;
  logic [K_W-1:0]                k;
  logic                          blank_q;
  logic                          slot_blank;
  logic [DEPTH-1:0][LINE_W-1:0]  view_q;
  logic                          idle_ev;
  logic                          push_fire;
  logic                          up_fire;
  logic                          down_fire;

  assign push_ready = started && (state == ST_IDLE);
  assign busy       = (state == ST_REFRESH);
  assign view       = view_q;

  assign idle_ev   = push_ready && !clear;
  assign push_fire = idle_ev && push_valid;
  assign up_fire   = idle_ev && !push_valid && scroll_up && !scroll_down &&
                     (32'(scroll_pos) + DEPTH < 32'(count));
  assign down_fire = idle_ev && !push_valid && scroll_down && !scroll_up &&
                     (scroll_pos != '0);

  // Address for slot k; only meaningful while refreshing, always kept in range.
  assign rd_addr    = PTR_W'(wrap_sub(32'(wr_ptr), 32'(scroll_pos) + 32'(k) + 32'd1, HIST));
  assign slot_blank = (32'(scroll_pos) + 32'(k) >= 32'(count));

  msglog_ram #(
    .ENTRIES (HIST),
    .WIDTH   (LINE_W)
  ) u_ram (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr),
    .wdata (push_line),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      started    <= 1'b0;
      wr_ptr     <= '0;
      count      <= '0;
      scroll_pos <= '0;
      overflow   <= 1'b0;
      k          <= '0;
      blank_q    <= 1'b1;
      view_q     <= {DEPTH{BLANK}};
    end else begin
      started <= 1'b1;
      if (clear) begin
        count      <= '0;
        scroll_pos <= '0;
        overflow   <= 1'b0;
        k          <= '0;
        state      <= ST_REFRESH;
      end else if (state == ST_IDLE) begin
        if (push_fire) begin
          wr_ptr <= (wr_ptr == PTR_W'(HIST - 1)) ? '0 : wr_ptr + PTR_W'(1);
          if (count == CNT_W'(HIST)) overflow <= 1'b1;
          else                       count    <= count + CNT_W'(1);
          scroll_pos <= '0;
          k          <= '0;
          state      <= ST_REFRESH;
        end else if (up_fire) begin
          scroll_pos <= scroll_pos + PTR_W'(1);
          k          <= '0;
          state      <= ST_REFRESH;
        end else if (down_fire) begin
          scroll_pos <= scroll_pos - PTR_W'(1);
          k          <= '0;
          state      <= ST_REFRESH;
        end
      end else begin
        // Slot k-1 lands while slot k's address is presented to the RAM.
        blank_q <= slot_blank;
        for (int unsigned s = 0; s < DEPTH; s++) begin
          if (32'(k) == s + 1) view_q[s] <= blank_q ? BLANK : rd_data;
        end
        if (32'(k) == DEPTH) begin
          k     <= '0;
          state <= ST_IDLE;
        end else begin
          k <= k + K_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_message_log.sv
// Directed self-checking bench for message_log (default HIST=8 and a HIST=7 instance).
module tb_message_log;
  import msglog_pkg::*;

  localparam int unsigned LW = 128;
  localparam logic [LW-1:0] LA   = 128'("A");
  localparam logic [LW-1:0] LB   = 128'("B");
  localparam logic [LW-1:0] LC   = 128'("C");
  localparam logic [LW-1:0] LZ   = 128'("ZZ");
  localparam logic [LW-1:0] LR1  = 128'("R1");
  localparam logic [LW-1:0] LR2  = 128'("R2");
  localparam logic [LW-1:0] LNEW = 128'("NEW");

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic pv8, pr8, clr8, up8, dn8, ovf8, busy8;
  logic [LW-1:0] pl8;
  logic [5*LW-1:0] view8;
  logic [3:0] cnt8;
  logic [2:0] sp8;
  logic pv7, pr7, clr7, up7, dn7, ovf7, busy7;
  logic [LW-1:0] pl7;
  logic [5*LW-1:0] view7;
  logic [2:0] cnt7, sp7;

  int total = 0;
  int passes = 0;

  message_log dut8 (
    .clk(clk), .reset(reset), .push_valid(pv8), .push_line(pl8), .push_ready(pr8),
    .clear(clr8), .scroll_up(up8), .scroll_down(dn8), .view(view8), .count(cnt8),
    .scroll_pos(sp8), .overflow(ovf8), .busy(busy8)
  );

  message_log #(.HIST(7)) dut7 (
    .clk(clk), .reset(reset), .push_valid(pv7), .push_line(pl7), .push_ready(pr7),
    .clear(clr7), .scroll_up(up7), .scroll_down(dn7), .view(view7), .count(cnt7),
    .scroll_pos(sp7), .overflow(ovf7), .busy(busy7)
  );

  function automatic logic [LW-1:0] lname(input int i);
    return {104'h0, "L", 8'(8'h30 + i / 10), 8'(8'h30 + i % 10)};
  endfunction

  function automatic logic [LW-1:0] slot8(input int k);
    return view8[k*LW +: LW];
  endfunction

  function automatic logic [LW-1:0] slot7(input int k);
    return view7[k*LW +: LW];
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_idle(input bit sel, input string tag, output int n);
    n = 0;
    while ((sel ? busy7 : busy8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(n < 50), 128'(1));
  endtask

  task automatic push(input bit sel, input logic [LW-1:0] l, input bit wait_done, output int lat);
    int n = 0;
    while (!(sel ? pr7 : pr8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_wait", 128'(n < 50), 128'(1));
    if (sel) begin pv7 = 1'b1; pl7 = l; end
    else     begin pv8 = 1'b1; pl8 = l; end
    @(negedge clk);
    pv7 = 1'b0;
    pv8 = 1'b0;
    lat = 0;
    if (wait_done) wait_idle(sel, "push_busy_timeout", lat);
  endtask

  task automatic scroll(input bit u, input bit d, output bit refreshed);
    int n;
    up8 = u;
    dn8 = d;
    @(negedge clk);
    up8 = 1'b0;
    dn8 = 1'b0;
    refreshed = busy8;
    wait_idle(1'b0, "scroll_busy_timeout", n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit r;
    reset = 1'b0;
    {pv8, clr8, up8, dn8, pv7, clr7, up7, dn7} = '0;
    pl8 = '0;
    pl7 = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);

    for (int k = 0; k < 5; k++) chk($sformatf("reset_slot%0d", k), slot8(k), BLANK_LINE);
    chk("reset_count", 128'(cnt8), 128'(0));
    chk("reset_ready", 128'(pr8), 128'(1));
    chk("reset_busy", 128'(busy8), 128'(0));
    chk("reset_ovf", 128'(ovf8), 128'(0));
    chk("reset_sp", 128'(sp8), 128'(0));

    // HIST=7 instance: wrap on a non-power-of-two history
    for (int i = 1; i <= 10; i++) push(1'b1, lname(i), 1'b1, lat);
    chk("h7_count", 128'(cnt7), 128'(7));
    chk("h7_ovf", 128'(ovf7), 128'(1));
    chk("h7_slot0", slot7(0), lname(10));
    chk("h7_slot2", slot7(2), lname(8));
    chk("h7_slot4", slot7(4), lname(6));
    chk("h7_view_known", 128'($isunknown(view7)), 128'(0));

    push(1'b0, LA, 1'b1, lat);
    chk("lat_A", 128'(lat), 128'(6));
    chk("after_A_slot0", slot8(0), LA);
    chk("after_A_slot1", slot8(1), BLANK_LINE);
    push(1'b0, LB, 1'b1, lat);
    push(1'b0, LC, 1'b1, lat);
    chk("lat_C", 128'(lat), 128'(6));
    chk("abc_slot0", slot8(0), LC);
    chk("abc_slot1", slot8(1), LB);
    chk("abc_slot2", slot8(2), LA);
    chk("abc_slot3", slot8(3), BLANK_LINE);
    chk("abc_slot4", slot8(4), BLANK_LINE);
    chk("abc_count", 128'(cnt8), 128'(3));

    scroll(1'b1, 1'b0, r);
    chk("up_cnt3_ignored", 128'(r), 128'(0));
    chk("up_cnt3_sp", 128'(sp8), 128'(0));

    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    wait_idle(1'b0, "clear_busy_timeout", lat);
    chk("clear_count", 128'(cnt8), 128'(0));
    chk("clear_slot0", slot8(0), BLANK_LINE);

    for (int i = 1; i <= 8; i++) push(1'b0, lname(i), 1'b1, lat);
    chk("full_count", 128'(cnt8), 128'(8));
    chk("full_ovf", 128'(ovf8), 128'(0));
    push(1'b0, lname(9), 1'b1, lat);
    chk("ovf_count", 128'(cnt8), 128'(8));
    chk("ovf_flag", 128'(ovf8), 128'(1));
    chk("ovf_slot0", slot8(0), lname(9));
    chk("ovf_slot4", slot8(4), lname(5));

    scroll(1'b1, 1'b0, r);
    chk("up1_sp", 128'(sp8), 128'(1));
    scroll(1'b1, 1'b0, r);
    chk("up2_sp", 128'(sp8), 128'(2));
    chk("up2_slot0", slot8(0), lname(7));
    chk("up2_slot4", slot8(4), lname(3));
    scroll(1'b1, 1'b0, r);
    chk("up3_accepted", 128'(r), 128'(1));
    chk("up3_slot4", slot8(4), lname(2));
    scroll(1'b1, 1'b0, r);
    chk("up4_ignored", 128'(r), 128'(0));
    chk("up4_sp", 128'(sp8), 128'(3));
    scroll(1'b1, 1'b1, r);
    chk("updown_ignored", 128'(r), 128'(0));
    chk("updown_sp", 128'(sp8), 128'(3));
    for (int i = 0; i < 3; i++) scroll(1'b0, 1'b1, r);
    chk("down_sp", 128'(sp8), 128'(0));
    chk("down_slot0", slot8(0), lname(9));
    scroll(1'b0, 1'b1, r);
    chk("down_at0_ignored", 128'(r), 128'(0));
    chk("ovf_sticky", 128'(ovf8), 128'(1));

    // clear together with push_valid in the second REFRESH cycle
    push(1'b0, lname(10), 1'b0, lat);
    @(negedge clk);
    clr8 = 1'b1;
    pv8 = 1'b1;
    pl8 = LZ;
    @(negedge clk);
    clr8 = 1'b0;
    pv8 = 1'b0;
    chk("clr_busy", 128'(busy8), 128'(1));
    chk("clr_count", 128'(cnt8), 128'(0));
    chk("clr_ovf", 128'(ovf8), 128'(0));
    repeat (5) @(negedge clk);
    chk("clr_busy_len", 128'(busy8), 128'(1));
    @(negedge clk);
    chk("clr_busy_done", 128'(busy8), 128'(0));
    for (int k = 0; k < 5; k++) chk($sformatf("clr_slot%0d", k), slot8(k), BLANK_LINE);
    chk("clr_count_final", 128'(cnt8), 128'(0));

    // asynchronous reset in the middle of a refresh
    push(1'b0, LR1, 1'b1, lat);
    push(1'b0, LR2, 1'b0, lat);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("areset_busy", 128'(busy8), 128'(0));
    chk("areset_count", 128'(cnt8), 128'(0));
    chk("areset_slot0", slot8(0), BLANK_LINE);
    chk("areset_sp", 128'(sp8), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    push(1'b0, LNEW, 1'b1, lat);
    chk("post_reset_slot0", slot8(0), LNEW);
    chk("post_reset_slot1", slot8(1), BLANK_LINE);
    chk("post_reset_count", 128'(cnt8), 128'(1));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
